mux4_rr_arbiter: RTL

//  Round-robin arbiter sharing the 4:1 one-bit mux (i0..i3 -> d, selects s1/s2) among four requesters.

---
 rtl/mux_arb_pkg.sv | 17 +
 rtl/rr_pick4.sv | 20 ++
 rtl/mux_arb_top.sv | 65 ++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared constants, state encoding and helpers for the 4-way round-robin mux arbiter
package mux_arb_pkg;
    localparam int N_REQ = 4;
    localparam int SEL_W = 2;
    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] sel);
        return N_REQ'(1) << sel;
    endfunction

    function automatic logic [N_REQ-1:0] rotr(input logic [N_REQ-1:0] v, input logic [SEL_W-1:0] sh);
        logic [2*N_REQ-1:0] t;
        t = {v, v} >> sh;
        return t[N_REQ-1:0];
    endfunction
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational round-robin winner search starting just after last
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    output logic             any,
    output logic [SEL_W-1:0] win
);
    logic [SEL_W-1:0] start;
    logic [N_REQ-1:0] rot;
    logic [SEL_W-1:0] off;
    always_comb begin
        start = last + 2'd1;
        rot   = rotr(req, start);
        off   = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
        win   = start + off;
        any   = |req;
    end
endmodule

// File: rtl/mux_arb_top.sv
// mux4_rr_arbiter: round-robin owner of a shared 4:1 mux with bounded hold and registered data
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       i0,
    input  logic       i1,
    input  logic       i2,
    input  logic       i3,
    output logic       s1,
    output logic       s2,
    output logic [3:0] gnt,
    output logic       d,
    output logic       d_valid
);
    localparam int HW = $clog2(MAX_HOLD) + 1;
    logic             state;
    logic [SEL_W-1:0] last;
    logic [HW-1:0]    hold_cnt;
    logic [N_REQ-1:0] data, others, pick_req;
    logic             any, owner_req, sat;
    logic [SEL_W-1:0] win;
    assign data      = {i3, i2, i1, i0};
    assign others    = req & ~gnt;
    assign pick_req  = (state == ST_GRANT) ? others : req;
    assign owner_req = |(req & gnt);
    assign sat       = hold_cnt == HW'(MAX_HOLD - 1);
    rr_pick4 u_pick (
        .req  (pick_req),
        .last (last),
        .any  (any),
        .win  (win)
    );
    // In GRANT, any/win describe competitors only, so one hand-off path covers release and rotation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            {s1, s2} <= '0;
            last     <= 2'd3;
            hold_cnt <= '0;
            d        <= 1'b0;
            d_valid  <= 1'b0;
        end else begin
            d       <= data[{s1, s2}];
            d_valid <= |gnt;
            if (any && (state == ST_IDLE || !owner_req || sat)) begin
                state    <= ST_GRANT;
                gnt      <= onehot(win);
                {s1, s2} <= win;
                last     <= win;
                hold_cnt <= '0;
            end else if (state == ST_GRANT && !owner_req) begin
                state <= ST_IDLE;
                gnt   <= '0;
            end else if (state == ST_GRANT && !sat) begin
                hold_cnt <= hold_cnt + HW'(1);
            end
        end
    end
endmodule
